// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_pkg                                                          |
// | Brief  : Shared UART types, constants and tick-divisor helper              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DATA_BITS          = 8;

    function automatic int calc_div(input int sys_clk_freq, input int baud_rate,
                                    input int oversample, input int sim);
        int div;
        div = sys_clk_freq / (baud_rate * oversample);
        if (sim != 0 || div < 1) div = 1;
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_sync_fifo                                                    |
// | Brief  : Synchronous circular FIFO with registered show-ahead head entry   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_data,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem_q [c_DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr_q, r_rd_ptr_q;
    logic [DEPTH_LOG2:0] w_wr_ptr_d, w_rd_ptr_d;
    logic [WIDTH-1:0]    r_head_q, w_head_d;
    logic                w_push_ok, w_pop_ok;

    assign o_empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign o_full  = (r_wr_ptr_q[DEPTH_LOG2] != r_rd_ptr_q[DEPTH_LOG2]) &&
                     (r_wr_ptr_q[DEPTH_LOG2-1:0] == r_rd_ptr_q[DEPTH_LOG2-1:0]);
    assign o_count = r_wr_ptr_q - r_rd_ptr_q;
    assign o_data  = r_head_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_comb begin
        w_wr_ptr_d = w_push_ok ? r_wr_ptr_q + 1'b1 : r_wr_ptr_q;
        w_rd_ptr_d = w_pop_ok  ? r_rd_ptr_q + 1'b1 : r_rd_ptr_q;
        if (w_push_ok && (r_wr_ptr_q == w_rd_ptr_d)) begin
            w_head_d = i_data;
        end else begin
            w_head_d = r_mem_q[w_rd_ptr_d[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_q[r_wr_ptr_q[DEPTH_LOG2-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_head_q   <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_head_q   <= w_head_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_fifo                                                      |
// | Brief  : 8N1 UART receiver, 16x oversampled, feeding a byte FIFO.          |
// |          Define UART_RX_PARITY_EN for an even-parity bit and parity_err.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ    = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = OVERSAMPLE_DEFAULT,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int SIM             = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [DATA_BITS-1:0]     rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     frame_err,
    output logic                     overrun,
`ifdef UART_RX_PARITY_EN
    output logic                     parity_err,
`endif
    output logic                     busy
);

    localparam int c_DIV   = calc_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE, SIM);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SMP_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(DATA_BITS);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
    localparam logic [c_SMP_W-1:0] c_HALF_LAST = c_SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SMP_W-1:0] c_FULL_LAST = c_SMP_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_e c_AFTER_DATA = ST_PARITY;
`else
    localparam uart_state_e c_AFTER_DATA = ST_STOP;
`endif

    logic                 r_sync1_q, r_rx_s_q;
    uart_state_e          r_state_q, w_state_d;
    logic [c_DIV_W-1:0]   r_div_cnt_q, w_div_cnt_d;
    logic [c_SMP_W-1:0]   r_smp_cnt_q, w_smp_cnt_d;
    logic [c_BIT_W-1:0]   r_bit_idx_q, w_bit_idx_d;
    logic [DATA_BITS-1:0] r_shift_q, w_shift_d;
    logic                 r_frame_err_q, w_frame_err_d;
    logic                 r_overrun_q, w_overrun_d;
    logic                 r_busy_q;
    logic                 w_tick, w_half_done, w_bit_done;
    logic                 w_push, w_pop, w_fifo_full, w_fifo_empty, w_parity_bad;

`ifdef UART_RX_PARITY_EN
    logic r_parity_q, w_parity_d;
    logic r_parity_err_q, w_parity_err_d;
    assign w_parity_bad = ^{r_shift_q, r_parity_q};
    assign parity_err   = r_parity_err_q;
`else
    assign w_parity_bad = 1'b0;
`endif

    assign w_tick      = (r_state_q != ST_IDLE) && (r_div_cnt_q == c_DIV_LAST);
    assign w_half_done = w_tick && (r_smp_cnt_q == c_HALF_LAST);
    assign w_bit_done  = w_tick && (r_smp_cnt_q == c_FULL_LAST);
    assign w_pop       = rx_valid && rx_ready;

    assign rx_valid  = !w_fifo_empty;
    assign frame_err = r_frame_err_q;
    assign overrun   = r_overrun_q;
    assign busy      = r_busy_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_div_cnt_d   = r_div_cnt_q;
        w_smp_cnt_d   = r_smp_cnt_q;
        w_bit_idx_d   = r_bit_idx_q;
        w_shift_d     = r_shift_q;
        w_push        = 1'b0;
        w_frame_err_d = 1'b0;
        w_overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_d     = r_parity_q;
        w_parity_err_d = 1'b0;
`endif
        if (w_tick) begin
            w_div_cnt_d = '0;
            w_smp_cnt_d = r_smp_cnt_q + 1'b1;
        end else if (r_state_q != ST_IDLE) begin
            w_div_cnt_d = r_div_cnt_q + 1'b1;
        end

        case (r_state_q)
            ST_IDLE: begin
                w_div_cnt_d = '0;
                w_smp_cnt_d = '0;
                if (!r_rx_s_q) w_state_d = ST_START;
            end
            ST_START: if (w_half_done) begin
                w_smp_cnt_d = '0;
                w_bit_idx_d = '0;
                w_state_d   = r_rx_s_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (w_bit_done) begin
                w_smp_cnt_d = '0;
                w_shift_d   = {r_rx_s_q, r_shift_q[DATA_BITS-1:1]};
                if (r_bit_idx_q == c_LAST_BIT) w_state_d = c_AFTER_DATA;
                else                           w_bit_idx_d = r_bit_idx_q + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (w_bit_done) begin
                w_smp_cnt_d = '0;
                w_parity_d  = r_rx_s_q;
                w_state_d   = ST_STOP;
            end
`endif
            ST_STOP: if (w_bit_done) begin
                w_smp_cnt_d = '0;
                // A low stop bit outranks a parity mismatch and parks us until the line recovers.
                if (!r_rx_s_q) begin
                    w_frame_err_d = 1'b1;
                    w_state_d     = ST_BREAK;
                end else begin
                    w_state_d = ST_IDLE;
                    if (w_parity_bad) begin
`ifdef UART_RX_PARITY_EN
                        w_parity_err_d = 1'b1;
`endif
                    end else if (w_fifo_full && !w_pop) begin
                        w_overrun_d = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            ST_BREAK: if (r_rx_s_q) w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q     <= 1'b1;
            r_rx_s_q      <= 1'b1;
            r_state_q     <= ST_IDLE;
            r_div_cnt_q   <= '0;
            r_smp_cnt_q   <= '0;
            r_bit_idx_q   <= '0;
            r_shift_q     <= '0;
            r_frame_err_q <= 1'b0;
            r_overrun_q   <= 1'b0;
            r_busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_q     <= 1'b0;
            r_parity_err_q <= 1'b0;
`endif
        end else begin
            r_sync1_q     <= rx;
            r_rx_s_q      <= r_sync1_q;
            r_state_q     <= w_state_d;
            r_div_cnt_q   <= w_div_cnt_d;
            r_smp_cnt_q   <= w_smp_cnt_d;
            r_bit_idx_q   <= w_bit_idx_d;
            r_shift_q     <= w_shift_d;
            r_frame_err_q <= w_frame_err_d;
            r_overrun_q   <= w_overrun_d;
            r_busy_q      <= (w_state_d != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            r_parity_q     <= w_parity_d;
            r_parity_err_q <= w_parity_err_d;
`endif
        end
    end

    uart_sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_shift_q),
        .o_data  (rx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_rx_fifo                                                   |
// | Brief  : Self-checking bench for uart_rx_fifo at SIM=1 (16 clk per bit)    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

    localparam int c_LOG2 = 3;
    localparam int c_BIT  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx = 1'b1;
    logic            rx_ready = 1'b0;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [c_LOG2:0] fifo_count;
    logic            frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic            parity_err;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_count;
        logic [7:0] exp_head;
        int         exp_ferr;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .SYS_CLK_FREQ    (100000000),
        .BAUD_RATE       (115200),
        .OVERSAMPLE      (c_BIT),
        .FIFO_DEPTH_LOG2 (c_LOG2),
        .SIM             (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    initial forever begin
        @(posedge clk);
        #1;
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a rising edge; the line changes 1 time unit later and the task returns
    // 1 unit after the edge that ends the stop bit, with the line back high.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        #1 rx = 1'b0;
        repeat (c_BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (c_BIT) @(posedge clk);
        end
        #1 rx = stop;
        repeat (c_BIT) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain_expect(input logic [7:0] first, input int n);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk("drain_valid", 32'(rx_valid), 32'd1);
            chk("drain_data", 32'(rx_data), 32'(first) + 32'(k));
            @(posedge clk);
            #1;
        end
        rx_ready = 1'b0;
        chk("drain_empty_valid", 32'(rx_valid), 32'd0);
        chk("drain_empty_count", 32'(fifo_count), 32'd0);
    endtask

    task automatic fill_incrementing(input int n);
        for (int d = 1; d <= n; d++) begin
            @(posedge clk);
            send_frame(8'(d), 1'b1);
        end
    endtask

    initial begin
        int   f0, o0, guard;
        bit   send_done;
        logic [7:0] model_q[$];
        logic [7:0] b;

        tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        tbl[1] = '{8'h00, 1'b1, 2, 8'hA5, 0};
        tbl[2] = '{8'hFF, 1'b0, 2, 8'hA5, 1};
        tbl[3] = '{8'h5A, 1'b1, 3, 8'hA5, 0};
        tbl[4] = '{8'h80, 1'b0, 3, 8'hA5, 1};
        tbl[5] = '{8'h7E, 1'b1, 4, 8'hA5, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;

        // First-byte latency: 155 cycles from the start edge to rx_valid
        repeat (4) @(posedge clk);
        f0 = n_ferr; o0 = n_ovr;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 chk("lat_valid_154", 32'(rx_valid), 32'd0);
                @(posedge clk);
                #1;
                chk("lat_valid_155", 32'(rx_valid), 32'd1);
                chk("lat_data", 32'(rx_data), 32'hA5);
                chk("lat_count", 32'(fifo_count), 32'd1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("lat_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("lat_no_ovr", 32'(n_ovr - o0), 32'd0);

        // Short low glitch aborts at mid start bit
        do_reset();
        repeat (4) @(posedge clk);
        f0 = n_ferr;
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        chk("glitch_busy_high", 32'(busy), 32'd1);
        repeat (16) @(posedge clk);
        #1;
        chk("glitch_busy_low", 32'(busy), 32'd0);
        chk("glitch_count", 32'(fifo_count), 32'd0);
        chk("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Table-driven frames, good and bad stop bits, consumer stalled
        do_reset();
        model_q.delete();
        for (int i = 0; i < 6; i++) begin
            f0 = n_ferr;
            @(posedge clk);
            send_frame(tbl[i].data, tbl[i].stop);
            if (tbl[i].stop) model_q.push_back(tbl[i].data);
            repeat (4) @(posedge clk);
            #1;
            chk("tbl_count", 32'(fifo_count), 32'(tbl[i].exp_count));
            chk("tbl_head", 32'(rx_data), 32'(tbl[i].exp_head));
            chk("tbl_ferr", 32'(n_ferr - f0), 32'(tbl[i].exp_ferr));
            chk("tbl_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1 rx_ready = 1'b1;
        while (model_q.size() != 0) begin
            b = model_q.pop_front();
            chk("tbl_pop", 32'(rx_data), 32'(b));
            @(posedge clk);
            #1;
        end
        rx_ready = 1'b0;
        chk("tbl_drained", 32'(rx_valid), 32'd0);

        // Line held low from reset release: one frame_err, stays in BREAK
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        f0 = n_ferr;
        #1 rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("break_ferr_once", 32'(n_ferr - f0), 32'd1);
        chk("break_busy", 32'(busy), 32'd1);
        chk("break_count", 32'(fifo_count), 32'd0);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("break_exit", 32'(busy), 32'd0);

        // Overrun: nine bytes into an eight-entry FIFO
        do_reset();
        o0 = n_ovr;
        fill_incrementing(9);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_pulse", 32'(n_ovr - o0), 32'd1);
        chk("ovr_count", 32'(fifo_count), 32'd8);
        chk("ovr_head", 32'(rx_data), 32'h01);
        drain_expect(8'h01, 8);

        // Pop coincides with the push into a full FIFO
        do_reset();
        fill_incrementing(8);
        @(posedge clk);
        o0 = n_ovr;
        fork
            send_frame(8'h09, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
                chk("pp_count", 32'(fifo_count), 32'd8);
                chk("pp_head", 32'(rx_data), 32'h02);
            end
        join
        repeat (4) @(posedge clk);
        #1 chk("pp_no_ovr", 32'(n_ovr - o0), 32'd0);
        drain_expect(8'h02, 8);

        // Reset in the middle of a frame
        do_reset();
        @(posedge clk);
        send_frame(8'h11, 1'b1);
        repeat (2) @(posedge clk);
        #1 chk("mid_prefill", 32'(rx_valid), 32'd1);
        f0 = n_ferr; o0 = n_ovr;
        @(posedge clk);
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (60) @(posedge clk);
                #1 chk("mid_busy_before", 32'(busy), 32'd1);
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("mid_busy_after", 32'(busy), 32'd0);
                chk("mid_valid_after", 32'(rx_valid), 32'd0);
            end
        join
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1;
                chk("mid_next_data", 32'(rx_data), 32'hC3);
                chk("mid_next_count", 32'(fifo_count), 32'd1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("mid_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("mid_no_ovr", 32'(n_ovr - o0), 32'd0);

        // Random bytes, random gaps, random consumer readiness against an in-order queue model
        do_reset();
        exp_q.delete();
        send_done = 1'b0;
        guard = 0;
        f0 = n_ferr; o0 = n_ovr;
        fork
            begin
                for (int n = 0; n < 12; n++) begin
                    repeat ($urandom_range(0, 20)) @(posedge clk);
                    @(posedge clk);
                    b = 8'($urandom_range(0, 255));
                    exp_q.push_back(b);
                    send_frame(b, 1'b1);
                end
                repeat (4) @(posedge clk);
                send_done = 1'b1;
            end
            begin
                while ((!send_done || exp_q.size() != 0) && guard < 5000) begin
                    @(posedge clk);
                    #1 rx_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (rx_valid && rx_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rnd_unexpected_pop", 32'(rx_data), 32'hFFFF_FFFF);
                        end else begin
                            chk("rnd_pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
                        end
                    end
                    guard++;
                end
            end
        join
        rx_ready = 1'b0;
        chk("rnd_all_received", 32'(exp_q.size()), 32'd0);
        chk("rnd_count", 32'(fifo_count), 32'd0);
        chk("rnd_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("rnd_no_ovr", 32'(n_ovr - o0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front end. Consumes the serial Rx line driven into riscv_top by the board pin or by the simulation bench.
- Deserialises 8N1 frames using 16x oversampling.
- Buffers received bytes in a small FIFO and presents them to the host-communication/CPU side over a valid/ready handshake.
- Sits directly behind the Rx pin, upstream of the byte consumer.

Parameters:
- SYS_CLK_FREQ, 100000000, system clock frequency in Hz
- BAUD_RATE, 115200, line baud rate
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4
- FIFO_DEPTH_LOG2, 3, log2 of the FIFO depth (8 entries)
- SIM, 0, when 1 the tick divisor is forced to 1 (one tick per clk)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line; idles high
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer accepts the head byte when rx_valid & rx_ready
- fifo_count  output  FIFO_DEPTH_LOG2+1  number of bytes currently stored
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: all outputs are 0, rx_data=8'h00. FSM goes to IDLE, FIFO empties, synchroniser flops are set to 1, tick counter clears. Reset mid-frame abandons the frame with no pulses.
- Synchroniser: two-flop on rx, producing rx_s. All decisions use rx_s, giving 2 cycles of input latency.
- Tick generator: DIV = SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division with minimum 1. DIV=1 when SIM=1. The tick is high one cycle in every DIV and runs free while not IDLE. Entering START resets the divisor counter and the sample counter.
- FSM states: IDLE, START, DATA, STOP, BREAK (plus PARITY under the optional feature).
  - IDLE: rx_s=0 -> START.
  - START: after OVERSAMPLE/2 ticks (mid-bit), sample rx_s. If 1 -> IDLE (glitch, no pulse). If 0 -> DATA with bit index 0.
  - DATA: sample every OVERSAMPLE ticks, LSB first, into a shift register. After bit 7 -> STOP.
  - STOP: sample after OVERSAMPLE ticks.
    - Sample 1 and FIFO not full: push byte, -> IDLE.
    - Sample 1 and FIFO full: overrun pulse, byte dropped, -> IDLE.
    - Sample 0: frame_err pulse, byte dropped, -> BREAK.
  - BREAK: wait until rx_s=1, then -> IDLE. A line held low therefore yields exactly one frame_err, not repeated frames.
- FIFO:
  - Circular buffer with read/write pointers FIFO_DEPTH_LOG2+1 bits wide; full = MSBs differ and lower bits equal.
  - rx_data is the registered head entry (show-ahead). A push into an empty FIFO makes rx_valid high the next cycle.
  - Pop on rx_valid & rx_ready. Simultaneous push and pop when full is legal: the pop frees a slot, so there is no overrun and fifo_count is unchanged.
  - Simultaneous push and pop when empty: the push happens and no pop occurs (rx_valid was 0).
- Latency at SIM=1, OVERSAMPLE=16: the falling edge at the pin to rx_valid is 2 + 8 + 8*16 + 16 + 1 cycles = 155.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. One even-parity bit is sampled OVERSAMPLE ticks after bit 7. A mismatch raises an extra output parity_err (1-bit, one-cycle pulse) after the stop bit and the byte is dropped. A parity error with a low stop bit reports frame_err only.
- Undefined: the parity_err port and the PARITY state are absent; frames are 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (3-bit enum)
  - constants OVERSAMPLE_DEFAULT and DATA_BITS=8
  - a function computing DIV from frequency, baud, oversample and SIM
- One sub-module, uart_sync_fifo: a parameterised synchronous FIFO (push, pop, data in/out, full, empty, count), reusable by a future TX path.

Test Plan:
- SIM=1, send 8'hA5 as 8N1 at 16 clk/bit -> 155 cycles after the start edge rx_data=8'hA5, rx_valid=1, fifo_count=1; no error pulses.
- Low glitch of 4 clk on idle rx -> START aborts at mid-bit; busy returns to 0; fifo_count stays 0; no pulses.
- Hold rx=0 from reset release for 300 clk -> exactly one frame_err pulse at the stop-bit sample, FSM stays in BREAK, no FIFO push. Raise rx -> IDLE.
- rx_ready=0, send bytes 8'h01..8'h09 -> first 8 stored, fifo_count=8, the 9th gives one overrun pulse. Then hold rx_ready=1 -> pops 8'h01..8'h08 in order, one per cycle.
- FIFO full, rx_ready pulsed in the same cycle as the 9th stop-bit push -> no overrun, fifo_count stays 8, head advances to 8'h02.
- Assert rst mid-DATA of 8'h3C -> next cycle busy=0 and rx_valid=0. The following clean frame 8'hC3 is received correctly.
